r_dot_mac: RTL
==============

R_DOT_MAC -- requirements
Module: r_dot_mac

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have start in 1: begin a new dot product; honoured only in IDLE.
REQ-003 SHALL have in_valid in 1: q_in carries a valid element this cycle.
REQ-004 SHALL have q_in in 16: serialized q_i element, signed Q8.8, fed in order q1, q2, q3.
REQ-005 SHALL have a1, a2, a3 in 16 each: column a_j, signed Q8.8, held stable from start until r_valid.
REQ-006 SHALL have r_out out 16: r_ij = q_i · a_j, signed Q8.8, rounded and saturated.
REQ-007 SHALL have r_valid out 1: one-cycle pulse, r_out is new.
REQ-008 SHALL have busy out 1: high in ACC and ROUND.
REQ-009 SHALL have ovf out 1: saturation occurred on the last result; sticky until next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, ACC, ROUND.
REQ-011 In IDLE, start SHALL clear acc to 0, clear idx to 0, clear ovf, and move to ACC; in_valid in IDLE SHALL be ignored.
REQ-012 In ACC, each cycle with in_valid=1 SHALL add q_in*a[idx] to acc (a[0]=a1, a[1]=a2, a[2]=a3) and increment idx; cycles with in_valid=0 SHALL hold acc and idx.
REQ-013 When the element at idx=2 is accepted, the FSM SHALL go to ROUND next cycle.
REQ-014 Products SHALL be full 32-bit signed; acc SHALL be 34-bit signed, with no wrap possible for 3 terms.
REQ-015 In ROUND: r = (acc + 128) >>> 8 (arithmetic shift, round half up); saturate r to [-32768, 32767]; register into r_out; pulse r_valid; set ovf if saturated; return to IDLE.
REQ-016 Latency: r_valid SHALL assert exactly one cycle after the cycle accepting the third element.
REQ-017 start while busy=1 SHALL be ignored; start coincident with r_valid (ROUND) SHALL be ignored.
REQ-018 start and in_valid in the same IDLE cycle: start SHALL be honoured and the element SHALL be dropped; the first element is accepted no earlier than the cycle after start.
REQ-019 r_out and ovf SHALL hold their values until the next ROUND or reset.
REQ-020 in_valid in ROUND SHALL be ignored.

Reset
REQ-021 reset SHALL dominate all inputs and force IDLE, acc=0, idx=0, r_out=0, r_valid=0, busy=0, ovf=0.
REQ-022 reset mid-ACC SHALL abandon the partial sum, with no r_valid pulse produced.

Structure
REQ-023 SHALL place Q_W=16, FRAC=8, ACC_W=34, VEC_LEN=3 and the FSM state enum in shared package qr_pkg.
REQ-024 SHALL implement rounding and saturation (REQ-015) as sub-module q_round_sat (34-bit in, 16-bit out, sat flag), purely combinational.

Verification
REQ-025 Case 1: start; q_in 0x0100,0x0000,0x0000 on consecutive cycles; a=(0x0200,0x0300,0x0400) -> r_out=0x0200, r_valid one cycle after third element, ovf=0.
REQ-026 Case 2: q=(0x0100,0x0100,0x0100) with in_valid gaps of 2 cycles; a=(0x0100,0x0200,0xFF00) -> r_out=0x0200; busy high throughout.
REQ-027 Case 3: q=a=(0x7FFF,0x7FFF,0x7FFF) -> r_out=0x7FFF, ovf=1; next start clears ovf.
REQ-028 Case 4: q=(0x0080,0,0), a=(0xFF80,0,0) -> r_out=0xFFC0 (-0.25); q=(0x8000,0x8000,0) with a=(0x7FFF,0x7FFF,0) -> r_out=0x8000, ovf=1.
REQ-029 Case 5: reset after 2 accepted elements -> no r_valid, busy=0 next cycle; a fresh run of Case 1 gives 0x0200.
REQ-030 Case 6: start pulsed during ACC and during ROUND -> ignored and the result is unchanged; start+in_valid in IDLE -> element dropped, three further elements needed.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared widths and FSM encoding for the Q8.8 dot-product MAC.
// Q_W-bit signed Q8.8 operands, ACC_W-bit accumulator, VEC_LEN-element vectors.
package qr_pkg;
  localparam int Q_W     = 16;
  localparam int FRAC    = 8;
  localparam int ACC_W   = 34;
  localparam int VEC_LEN = 3;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2
  } state_t;
endpackage

// File: rtl/q_round_sat.sv
// Round-half-up from FRAC fractional bits, then saturate to signed Q_W.
// Purely combinational; no flow control.
module q_round_sat
  import qr_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  output logic        [Q_W-1:0]   r_out,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 << (FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (Q_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    // acc can reach only ~3*2^30, so adding the half-LSB cannot overflow ACC_W
    rounded = (acc_in + RND) >>> FRAC;
    r_out   = rounded[Q_W-1:0];
    sat     = 1'b0;
    if (rounded > SAT_HI) begin
      r_out = SAT_HI[Q_W-1:0];
      sat   = 1'b1;
    end else if (rounded < SAT_LO) begin
      r_out = SAT_LO[Q_W-1:0];
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/r_dot_mac.sv
// Serial 3-term Q8.8 dot product q.a with rounding/saturation; r_valid one cycle
// after the third accepted element. No backpressure: in_valid accepted whenever in ACC.
module r_dot_mac
  import qr_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           in_valid,
  input  logic [Q_W-1:0] q_in,
  input  logic [Q_W-1:0] a1,
  input  logic [Q_W-1:0] a2,
  input  logic [Q_W-1:0] a3,
  output logic [Q_W-1:0] r_out,
  output logic           r_valid,
  output logic           busy,
  output logic           ovf
);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic        [IDX_W-1:0]  idx;
  logic        [Q_W-1:0]    a_sel;
  logic signed [2*Q_W-1:0]  prod;
  logic        [Q_W-1:0]    rs_r;
  logic                     rs_sat;
  logic                     start_ok;
  logic                     accept;
  logic                     last;

  always_comb begin
    a_sel = a3;
    case (idx)
      2'd0:    a_sel = a1;
      2'd1:    a_sel = a2;
      default: a_sel = a3;
    endcase
  end

  assign prod    = $signed(q_in) * $signed(a_sel);
  assign acc_nxt = acc + ACC_W'(prod);
  assign last    = (idx == LAST_IDX);

  // Round the final sum in the accepting cycle so r_out is already new while
  // r_valid is high in ROUND; this meets the one-cycle latency with registered outputs.
  q_round_sat u_round_sat (
    .acc_in (acc_nxt),
    .r_out  (rs_r),
    .sat    (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          accept = 1'b1;
          if (last) state_nxt = ROUND;
        end
      end
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACC) || (state == ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      idx     <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (start_ok) begin
        acc <= '0;
        idx <= '0;
        ovf <= 1'b0;
      end
      if (accept) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (last) begin
          r_out   <= rs_r;
          ovf     <= rs_sat;
          r_valid <= 1'b1;
        end
      end
    end
  end

endmodule
